mem_arbiter: RTL and testbench

- Shares the single-ported RAM between instruction fetch (read-only) and the memory stage (load/store).
- One transaction at a time. Accepts a request, sequences the RAM address, write-enable and read-latency wait, then returns data and a one-cycle ready pulse to the requester.
- Generates the fetch and memory-stage stall signals the pipeline uses while a request is pending.

---
 rtl/mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-ported RAM arbiter for instruction fetch and memory stage
//
// Shares one RAM between the fetch port (read-only) and the data port (load/store).
// One transaction at a time. On a tie, the port opposite the last grant wins.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   if_req/if_addr        fetch request and address (held until if_ready)
//   if_rdata/if_ready     fetched word and one-cycle completion pulse
//   d_req/d_we/d_addr/d_wdata  data request (d_we=1 store, 0 load)
//   d_rdata/d_ready       load result and one-cycle completion pulse
//   ram_addr/ram_wdata/ram_we/ram_rdata  RAM side
//   stall_fetch/stall_mem request pending and not yet complete
module mem_arbiter #(
  parameter int unsigned RAM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic        ram_we,
  input  logic [31:0] ram_rdata,
  output logic        stall_fetch,
  output logic        stall_mem
);

  typedef enum logic [2:0] {IDLE, FETCH_RD, DATA_RD, DATA_WR, DONE} state_t;

  localparam logic [3:0] LAT = 4'(RAM_LATENCY);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_grant_q, last_grant_d;   // 0 = fetch, 1 = data
  logic [31:0] ram_addr_q, ram_addr_d;
  logic [31:0] ram_wdata_q, ram_wdata_d;
  logic        ram_we_q, ram_we_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        if_ready_q, if_ready_d;
  logic        d_ready_q, d_ready_d;
  logic        grant_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      last_grant_q <= 1'b0;
      ram_addr_q   <= 32'd0;
      ram_wdata_q  <= 32'd0;
      ram_we_q     <= 1'b0;
      if_rdata_q   <= 32'd0;
      d_rdata_q    <= 32'd0;
      if_ready_q   <= 1'b0;
      d_ready_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      ram_we_q     <= ram_we_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
      if_ready_q   <= if_ready_d;
      d_ready_q    <= d_ready_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    ram_we_d     = 1'b0;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    if_ready_d   = 1'b0;
    d_ready_d    = 1'b0;
    // Data wins when alone, or on a tie when fetch had the previous grant.
    grant_data   = d_req & (~if_req | ~last_grant_q);

    case (state_q)
      IDLE: begin
        if (if_req | d_req) begin
          last_grant_d = grant_data;
          cnt_d        = 4'd0;
          if (grant_data) begin
            ram_addr_d = d_addr;
            if (d_we) begin
              ram_wdata_d = d_wdata;
              ram_we_d    = 1'b1;
              state_d     = DATA_WR;
            end else begin
              state_d = DATA_RD;
            end
          end else begin
            ram_addr_d = if_addr;
            state_d    = FETCH_RD;
          end
        end
      end
      FETCH_RD, DATA_RD: begin
        // Counter is 0 in the first wait cycle, so it reaches LAT exactly
        // when the RAM output becomes valid.
        if (cnt_q == LAT) begin
          if (state_q == FETCH_RD) begin
            if_rdata_d = ram_rdata;
            if_ready_d = 1'b1;
          end else begin
            d_rdata_d = ram_rdata;
            d_ready_d = 1'b1;
          end
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DATA_WR: begin
        d_ready_d = 1'b1;
        state_d   = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ram_addr    = ram_addr_q;
  assign ram_wdata   = ram_wdata_q;
  assign ram_we      = ram_we_q;
  assign if_rdata    = if_rdata_q;
  assign d_rdata     = d_rdata_q;
  assign if_ready    = if_ready_q;
  assign d_ready     = d_ready_q;
  assign stall_fetch = if_req & ~if_ready_q;
  assign stall_mem   = d_req & ~d_ready_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter against a transaction-timing model
module tb_mem_arbiter;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata, ram_rdata;
  logic [31:0] if_rdata, d_rdata, ram_addr, ram_wdata;
  logic        if_ready, d_ready, ram_we, stall_fetch, stall_mem;

  always #5 clk = ~clk;

  mem_arbiter #(.RAM_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
    .stall_fetch(stall_fetch), .stall_mem(stall_mem)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Requesters: index 0 = fetch, 1 = data
  logic        pend [2];
  logic        r_we [2];
  logic [31:0] r_addr [2];
  logic [31:0] r_wdata [2];
  logic [31:0] r_data [2];

  // Transaction-level model of the arbiter
  int          cyc;
  logic        busy;
  int          g_cyc, rdy_cyc, cur_port, last_port;
  logic        cur_store;
  logic [31:0] cur_addr, cur_wdata, cur_data;
  logic [31:0] e_ram_addr, e_ram_wdata, e_if_rdata, e_d_rdata;
  int          obs[$];   // order of ready pulses seen on the DUT

  task automatic chk(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
    n_checks++;
    assert (obs_v === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs_v, exp_v);
    end
  endtask

  task automatic issue(input int p, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] data);
    pend[p]    = 1'b1;
    r_we[p]    = (p == 1) ? we : 1'b0;
    r_addr[p]  = addr;
    r_wdata[p] = wdata;
    r_data[p]  = data;
  endtask

  task automatic model_clear();
    busy = 1'b0; last_port = 0; g_cyc = -100; rdy_cyc = -100;
    cur_port = 0; cur_store = 1'b0;
    e_ram_addr = '0; e_ram_wdata = '0; e_if_rdata = '0; e_d_rdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pend[0] = 1'b0; pend[1] = 1'b0;
    if_req = 1'b0; d_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    cyc++;
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic tick();
    logic exp_ifr, exp_dr, exp_we;
    int   p;
    int   lat;
    if_req  = pend[0];
    if_addr = pend[0] ? r_addr[0] : $urandom;
    d_req   = pend[1];
    d_we    = pend[1] ? r_we[1] : 1'($urandom);
    d_addr  = pend[1] ? r_addr[1] : $urandom;
    d_wdata = pend[1] ? r_wdata[1] : $urandom;
    // RAM data is only meaningful in the single cycle a read expects it.
    if (busy && !cur_store && cyc == g_cyc + 1 + LAT) ram_rdata = cur_data;
    else ram_rdata = $urandom;
    if (busy && cyc == g_cyc + 1) begin
      e_ram_addr = cur_addr;
      if (cur_store) e_ram_wdata = cur_wdata;
    end
    if (busy && cyc == rdy_cyc && !cur_store) begin
      if (cur_port == 0) e_if_rdata = cur_data;
      else e_d_rdata = cur_data;
    end
    exp_ifr = busy && cyc == rdy_cyc && cur_port == 0;
    exp_dr  = busy && cyc == rdy_cyc && cur_port == 1;
    exp_we  = busy && cur_store && cyc == g_cyc + 1;
    #1;
    chk("ram_addr", ram_addr, e_ram_addr);
    chk("ram_wdata", ram_wdata, e_ram_wdata);
    chk("ram_we", 32'(ram_we), 32'(exp_we));
    chk("if_ready", 32'(if_ready), 32'(exp_ifr));
    chk("d_ready", 32'(d_ready), 32'(exp_dr));
    chk("if_rdata", if_rdata, e_if_rdata);
    chk("d_rdata", d_rdata, e_d_rdata);
    chk("stall_fetch", 32'(stall_fetch), 32'(pend[0] && !exp_ifr));
    chk("stall_mem", 32'(stall_mem), 32'(pend[1] && !exp_dr));
    if (if_ready === 1'b1) obs.push_back(0);
    if (d_ready === 1'b1) obs.push_back(1);
    if (busy) begin
      if (cyc == rdy_cyc) begin
        busy = 1'b0;
        pend[cur_port] = 1'b0;
      end
    end else if (pend[0] || pend[1]) begin
      if (pend[0] && pend[1]) p = 1 - last_port;
      else p = pend[1] ? 1 : 0;
      cur_port  = p;
      cur_store = r_we[p];
      cur_addr  = r_addr[p];
      cur_wdata = r_wdata[p];
      cur_data  = r_data[p];
      lat       = cur_store ? 2 : LAT + 2;
      g_cyc     = cyc;
      rdy_cyc   = cyc + lat;
      last_port = p;
      busy      = 1'b1;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic wait_done(input int limit);
    for (int i = 0; i < limit && (busy || pend[0] || pend[1]); i++) tick();
    chk("timeout", 32'(busy || pend[0] || pend[1]), 32'd0);
  endtask

  initial begin
    logic [31:0] d2;
    int n;
    rst = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0; ram_rdata = '0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    cyc = 0;
    model_clear();
    @(posedge clk); #1;
    do_reset();
    tick();   // reset state: all outputs zero, nothing pending

    // Fetch only
    obs.delete();
    issue(0, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF);
    wait_done(20);
    chk("t1_if_rdata", if_rdata, 32'hDEADBEEF);
    chk("t1_ready_count", 32'(obs.size()), 32'd1);

    // Store
    issue(1, 1'b1, 32'h200, 32'h12345678, $urandom);
    wait_done(20);
    chk("t2_ram_wdata", ram_wdata, 32'h12345678);

    // Simultaneous first requests after reset: data first
    do_reset();
    obs.delete();
    issue(0, 1'b0, 32'h0, 32'h0, $urandom);
    issue(1, 1'b0, 32'h40, 32'h0, $urandom);
    wait_done(40);
    chk("t3_count", 32'(obs.size()), 32'd2);
    if (obs.size() == 2) begin
      chk("t3_first", 32'(obs[0]), 32'd1);
      chk("t3_second", 32'(obs[1]), 32'd0);
    end

    // Both ports requesting continuously: D,F,D,F,D,F
    do_reset();
    obs.delete();
    n = 0;
    while (obs.size() < 6 && n < 200) begin
      if (!pend[0]) issue(0, 1'b0, $urandom, 32'h0, $urandom);
      if (!pend[1]) issue(1, 1'($urandom), $urandom, $urandom, $urandom);
      tick();
      n++;
    end
    chk("t4_count", 32'(obs.size()), 32'd6);
    for (int i = 0; i < 6 && i < obs.size(); i++)
      chk($sformatf("t4_order%0d", i), 32'(obs[i]), (i % 2 == 0) ? 32'd1 : 32'd0);
    wait_done(40);

    // Reset in the second DATA_RD cycle abandons the load
    do_reset();
    obs.delete();
    issue(1, 1'b0, 32'h80, 32'h0, $urandom);
    tick();       // grant cycle
    tick();       // first DATA_RD cycle
    do_reset();   // second DATA_RD cycle
    tick();       // all outputs zero
    chk("t5_no_ready", 32'(obs.size()), 32'd0);
    issue(0, 1'b0, 32'h300, 32'h0, $urandom);
    wait_done(20);
    chk("t5_fetch_done", 32'(obs.size()), 32'd1);

    // Back-to-back loads
    issue(1, 1'b0, 32'h10, 32'h0, $urandom);
    n = 0;
    while (pend[1] && n < 20) begin tick(); n++; end
    d2 = $urandom;
    issue(1, 1'b0, 32'h14, 32'h0, d2);
    wait_done(20);
    chk("t6_d_rdata", d_rdata, d2);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if (!pend[0] && $urandom_range(1, 0) == 1) issue(0, 1'b0, $urandom, 32'h0, $urandom);
      if (!pend[1] && $urandom_range(1, 0) == 1) issue(1, 1'($urandom), $urandom, $urandom, $urandom);
      tick();
    end
    wait_done(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
